// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch and load/store) in front of one single-port memory
// with a fixed read latency and one access outstanding at a time.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int DMEM_PRIO  = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [STV_W-1:0]   starve_cnt;
    logic               win_d;
    logic               cur_we;
    logic               last_d;
    logic               pick_d;
    logic               in_flight;
    logic               starved;

    assign starved = (starve_cnt == STV_W'(STARVE_MAX));

    // Winner for the next arbitration edge; only used when at least one request is present.
    always_comb begin
        pick_d = 1'b0;
        if (d_req && !if_req) begin
            pick_d = 1'b1;
        end else if (d_req && if_req) begin
            if (DMEM_PRIO != 0) begin
                pick_d = !starved;
            end else begin
                pick_d = !last_d;
            end
        end
    end

    assign in_flight = (state == ISSUE) || (state == WAIT);
    assign stall_if  = (if_req | (in_flight & ~win_d)) & ~if_rvalid;
    assign stall_mem = (d_req  | (in_flight &  win_d)) & ~d_rvalid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            win_d      <= 1'b0;
            cur_we     <= 1'b0;
            last_d     <= 1'b1;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (if_req || d_req) begin
                        state  <= ISSUE;
                        mem_en <= 1'b1;
                        win_d  <= pick_d;
                        last_d <= pick_d;
                        if (pick_d) begin
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            cur_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                            if (if_req && !starved) begin
                                starve_cnt <= starve_cnt + STV_W'(1);
                            end
                        end else begin
                            if_gnt     <= 1'b1;
                            cur_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_be     <= '1;
                            starve_cnt <= '0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_W'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        if (win_d) begin
                            d_rvalid <= 1'b1;
                            if (!cur_we) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
